job_initiator: RTL

- Initiator for the phase-sequencer handshake.
- Accepts jobs from upstream on a req/ready handshake and drives the sequencer's start input.
- Monitors the sequencer's one-hot phase strobes {A,B,C,D,en,valid} for legal order, and reports completion, latency and protocol errors.
- Sits between the host/job-source logic and the sequencer inside the compute tile.

---
 rtl/job_initiator.sv | 138 +++++++++++++
 1 files changed

// File: rtl/job_initiator.sv
// rtl/job_initiator.sv - job handshake initiator and phase-order monitor for the phase sequencer
// Optional statistics (job_count, last_latency) built only when JOB_INIT_STATS_EN is defined.
module job_initiator #(
    parameter int TIMEOUT = 16,
    parameter int LAT_W   = 8,
    parameter int CNT_W   = 16
) (
    input  logic             clock,
    input  logic             rst_n,
    input  logic             req_in,
    output logic             req_ready,
    input  logic             err_clr,
    output logic             start,
    input  logic             A,
    input  logic             B,
    input  logic             C,
    input  logic             D,
    input  logic             en,
    input  logic             valid,
    output logic             busy,
    output logic             done,
    output logic             err,
    output logic [1:0]       err_code,
    output logic [CNT_W-1:0] job_count,
    output logic [LAT_W-1:0] last_latency
);

    typedef enum logic [1:0] {IDLE, ISSUE, RUN, ERR} state_t;

    localparam logic [5:0] S_IDLE = 6'b100000;

    state_t     state, next_state;
    logic [2:0] ph;
    logic [7:0] tmo;
    logic [5:0] s, exp_s;
    logic       job_done, err_set;
    logic [1:0] err_cause;

    assign s     = {A, B, C, D, en, valid};
    // ph=1 expects B, ph=5 expects valid: the idle strobe shifted right by ph
    assign exp_s = S_IDLE >> ph;

    assign start     = (state == ISSUE);
    assign busy      = (state == ISSUE) || (state == RUN);
    assign req_ready = (state == IDLE);

    always_ff @(posedge clock or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= next_state;
    end

    always_comb begin
        next_state = state;
        job_done   = 1'b0;
        err_set    = 1'b0;
        err_cause  = 2'b00;
        case (state)
            IDLE: if (req_in) next_state = ISSUE;
            ISSUE: begin
                if (s == S_IDLE) begin
                    next_state = RUN;
                end else if (tmo == 8'(TIMEOUT - 1)) begin
                    next_state = ERR;
                    err_set    = 1'b1;
                    err_cause  = 2'b01;
                end
            end
            RUN: begin
                if (s != exp_s) begin
                    next_state = ERR;
                    err_set    = 1'b1;
                    err_cause  = 2'b10;
                end else if (ph == 3'd5) begin
                    // Completion counts as IDLE, so a pending request issues without a gap
                    job_done   = 1'b1;
                    next_state = req_in ? ISSUE : IDLE;
                end
            end
            ERR: if (err_clr) next_state = IDLE;
            default: next_state = IDLE;
        endcase
    end

    always_ff @(posedge clock or negedge rst_n) begin
        if (!rst_n) begin
            ph       <= 3'd0;
            tmo      <= 8'd0;
            done     <= 1'b0;
            err      <= 1'b0;
            err_code <= 2'b00;
        end else begin
            if (next_state != RUN)  ph <= 3'd0;
            else if (state == ISSUE) ph <= 3'd1;
            else                     ph <= 3'(ph + 3'd1);

            if (state == ISSUE) tmo <= 8'(tmo + 8'd1);
            else                tmo <= 8'd0;

            done <= job_done;

            if (err_set) begin
                err      <= 1'b1;
                err_code <= err_cause;
            end else if (state == ERR && err_clr) begin
                err      <= 1'b0;
                err_code <= 2'b00;
            end
        end
    end

`ifdef JOB_INIT_STATS_EN
    localparam logic [LAT_W-1:0] LAT_MAX = '1;

    logic [LAT_W-1:0] lat;

    always_ff @(posedge clock or negedge rst_n) begin
        if (!rst_n) begin
            lat          <= '0;
            job_count    <= '0;
            last_latency <= '0;
        end else begin
            if (next_state == ISSUE && state != ISSUE)
                lat <= '0;
            else if ((state == ISSUE || state == RUN) && lat != LAT_MAX)
                lat <= lat + 1'b1;

            if (job_done) begin
                job_count    <= job_count + 1'b1;
                last_latency <= lat;
            end
        end
    end
`else
    assign job_count    = '0;
    assign last_latency = '0;
`endif

endmodule
